core_mem_arbiter: RTL and testbench

CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter
Interface
REQ-001 SHALL have parameter OUTSTANDING, default 2, giving the maximum number of accepted-but-unacknowledged bus transactions (1..4).
REQ-002 SHALL have port clk  in  1  the single clock; all state is on its rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port mem_i_rd  in  1  fetch request.
REQ-005 SHALL have port mem_i_pc  in  32  fetch address.
REQ-006 SHALL have port mem_i_accept  out  1  fetch request taken this cycle.
REQ-007 SHALL have port mem_i_valid  out  1  fetch response strobe.
REQ-008 SHALL have port mem_i_error  out  1  fetch response error.
REQ-009 SHALL have port mem_i_inst  out  32  fetch response data.
REQ-010 SHALL have port mem_d_addr  in  32  data address.
REQ-011 SHALL have port mem_d_data_wr  in  32  write data.
REQ-012 SHALL have port mem_d_rd  in  1  data read request.
REQ-013 SHALL have port mem_d_wr  in  4  byte write strobes; nonzero means write request.
REQ-014 SHALL have port mem_d_req_tag  in  11  data request tag.
REQ-015 SHALL have port mem_d_accept  out  1  data request taken this cycle.
REQ-016 SHALL have port mem_d_ack  out  1  data response strobe.
REQ-017 SHALL have port mem_d_error  out  1  data response error.
REQ-018 SHALL have port mem_d_data_rd  out  32  data read response.
REQ-019 SHALL have port mem_d_resp_tag  out  11  tag of the request being acknowledged.
REQ-020 SHALL have port bus_addr  out  32  shared memory address.
REQ-021 SHALL have port bus_data_wr  out  32  shared write data (zero for fetches).
REQ-022 SHALL have port bus_rd  out  1  shared read request.
REQ-023 SHALL have port bus_wr  out  4  shared write strobes (zero for fetches).
REQ-024 SHALL have port bus_accept  in  1  memory takes the presented request.
REQ-025 SHALL have port bus_ack  in  1  in-order response strobe.
REQ-026 SHALL have port bus_error  in  1  response error.
REQ-027 SHALL have port bus_data_rd  in  32  response data.
REQ-028 SHALL have port protocol_err  out  1  sticky flag: bus_ack arrived with nothing outstanding.
Function
REQ-029 SHALL treat i_req = mem_i_rd and d_req = mem_d_rd | (mem_d_wr != 0); presenting both mem_d_rd and a nonzero mem_d_wr is a write.
REQ-030 SHALL present a request on the bus only while outstanding count < OUTSTANDING; at count == OUTSTANDING it SHALL drive bus_rd = 0 and bus_wr = 0, even if bus_ack pops an entry in that cycle.
REQ-031 SHALL arbitrate round-robin: with both requests pending and no lock, it grants the source not granted last; last_grant resets to D, so I wins the first tie.
REQ-032 SHALL hold the selected source (lock register) from the first cycle it is presented until bus_accept, without switching, even if the other source requests.
REQ-033 SHALL drive the bus fields combinationally from the selected source.
REQ-034 SHALL drive mem_i_accept / mem_d_accept = selected & bus_accept; at most one of the two is high per cycle.
REQ-035 SHALL, on an accepted request, push {src, tag} (tag = 0 for I) into an in-order FIFO of depth OUTSTANDING.
REQ-036 SHALL, on bus_ack with a non-empty FIFO, pop the head entry and in the same cycle (zero latency) pulse only that source's response:
- I: mem_i_valid, mem_i_inst = bus_data_rd, mem_i_error = bus_error.
- D: mem_d_ack, mem_d_data_rd = bus_data_rd, mem_d_error = bus_error, mem_d_resp_tag = stored tag.
REQ-037 SHALL, on bus_ack with an empty FIFO, produce no response, set protocol_err (cleared only by reset), and leave the count unchanged.
REQ-038 SHALL allow push and pop in the same cycle (count unchanged); pointers wrap modulo OUTSTANDING.
REQ-039 SHALL drive all response data/error/tag outputs to 0 when their strobe is low.
Reset
REQ-040 SHALL, while rst is low, drive all outputs to 0, empty the FIFO, clear the lock, set last_grant = D, and clear protocol_err.
REQ-041 SHALL, on reset mid-operation, drop all outstanding entries; acks arriving after reset are treated per REQ-037.
Structure
REQ-042 SHALL take from package core_mem_arb_pkg: enum src_e {SRC_I, SRC_D}, struct arb_entry_t {src_e src; logic [10:0] tag;}, and the default OUTSTANDING.
REQ-043 SHALL implement the in-order FIFO as sub-module core_mem_arb_fifo (full/empty/count outputs).
Verification
REQ-044 SHALL test: I and D requesting together from reset, bus_accept = 1 -> cycle 1 grants I (pc 0x100), cycle 2 grants D (addr 0x2000, tag 0x05).
REQ-045 SHALL test: two acks with bus_data_rd 0xAAAA0001 then 0xBBBB0002 -> mem_i_inst = 0xAAAA0001, then mem_d_data_rd = 0xBBBB0002 with mem_d_resp_tag = 0x05.
REQ-046 SHALL test: OUTSTANDING = 2 and two unacked accepts -> bus_rd = 0 and both accepts = 0 until the first bus_ack.
REQ-047 SHALL test: D write (mem_d_wr = 4'b0011) held with bus_accept = 0 for 3 cycles while I requests -> bus stays on D until accept.
REQ-048 SHALL test: bus_ack with FIFO empty -> no strobes and protocol_err = 1 until rst is low.
REQ-049 SHALL test: rst low with 2 outstanding -> outputs 0 and count 0; the next request is granted normally.

---
 rtl/core_mem_arb_pkg.sv | 29 ++
 rtl/core_mem_arb_fifo.sv | 70 +++++++
 rtl/core_mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_core_mem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_arb_pkg.sv
// rtl/core_mem_arb_pkg.sv - shared types and defaults for the core memory arbiter
//
// Purpose: source encoding, in-order tracking entry and sizing constants used
//          by core_mem_arbiter and its response-ordering FIFO.
// Ports:   none (package).

package core_mem_arb_pkg;

  // Default number of accepted-but-unacknowledged bus transactions.
  localparam int OUTSTANDING_DEF = 2;

  // Width of the outstanding counter; holds 0..4 inclusive.
  localparam int CNT_W = 3;

  // Data request tag width.
  localparam int TAG_W = 11;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_e;

  // One entry per accepted bus request, in issue order. Fetches carry tag 0.
  typedef struct packed {
    src_e             src;
    logic [TAG_W-1:0] tag;
  } arb_entry_t;

endpackage

// File: rtl/core_mem_arb_fifo.sv
// rtl/core_mem_arb_fifo.sv - in-order FIFO recording which source owns each outstanding bus transaction
//
// Purpose: remembers {src, tag} for every accepted bus request so that the
//          in-order bus_ack stream can be steered back to the right requester.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   push, push_entry    write one entry (ignored when full)
//   pop                 drop the head entry (ignored when empty)
//   head                current head entry (valid when !empty)
//   full, empty, count  occupancy status

module core_mem_arb_fifo
  import core_mem_arb_pkg::*;
#(
  parameter int DEPTH = OUTSTANDING_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  arb_entry_t       push_entry,
  input  logic             pop,
  output arb_entry_t       head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  arb_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - round-robin arbiter sharing one in-order memory bus between fetch and data ports
//
// Purpose: merges the instruction-fetch (I) and data (D) request ports onto a
//          single memory bus, limits the number of unacknowledged transactions,
//          and routes each in-order bus response back to the port that issued it.
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   mem_i_rd, mem_i_pc                fetch request / address
//   mem_i_accept                      fetch request taken this cycle
//   mem_i_valid, mem_i_error,
//   mem_i_inst                        fetch response strobe / error / data
//   mem_d_addr, mem_d_data_wr,
//   mem_d_rd, mem_d_wr, mem_d_req_tag data request (nonzero mem_d_wr = write)
//   mem_d_accept                      data request taken this cycle
//   mem_d_ack, mem_d_error,
//   mem_d_data_rd, mem_d_resp_tag     data response strobe / error / data / tag
//   bus_addr, bus_data_wr,
//   bus_rd, bus_wr                    shared bus request
//   bus_accept                        memory takes the presented request
//   bus_ack, bus_error, bus_data_rd   in-order bus response
//   protocol_err                      sticky: bus_ack seen with nothing outstanding

module core_mem_arbiter
  import core_mem_arb_pkg::*;
#(
  parameter int OUTSTANDING = OUTSTANDING_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_i_rd,
  input  logic [31:0]      mem_i_pc,
  output logic             mem_i_accept,
  output logic             mem_i_valid,
  output logic             mem_i_error,
  output logic [31:0]      mem_i_inst,
  input  logic [31:0]      mem_d_addr,
  input  logic [31:0]      mem_d_data_wr,
  input  logic             mem_d_rd,
  input  logic [3:0]       mem_d_wr,
  input  logic [TAG_W-1:0] mem_d_req_tag,
  output logic             mem_d_accept,
  output logic             mem_d_ack,
  output logic             mem_d_error,
  output logic [31:0]      mem_d_data_rd,
  output logic [TAG_W-1:0] mem_d_resp_tag,
  output logic [31:0]      bus_addr,
  output logic [31:0]      bus_data_wr,
  output logic             bus_rd,
  output logic [3:0]       bus_wr,
  input  logic             bus_accept,
  input  logic             bus_ack,
  input  logic             bus_error,
  input  logic [31:0]      bus_data_rd,
  output logic             protocol_err
);

  logic             i_req;
  logic             d_req;
  logic             d_is_wr;
  logic             issue_ok;
  logic             present;
  src_e             sel;
  logic             accepted;
  logic             resp_pop;

  logic             lock_valid;
  src_e             lock_src;
  src_e             last_grant;

  arb_entry_t       push_entry;
  arb_entry_t       fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // A data request with any strobe set is a write, even if mem_d_rd is also high.
  assign i_req   = mem_i_rd;
  assign d_is_wr = |mem_d_wr;
  assign d_req   = mem_d_rd | d_is_wr;

  // Issue is blocked at the limit regardless of a same-cycle bus_ack; the
  // freed slot becomes usable on the following cycle.
  assign issue_ok = rst & (fifo_count < CNT_W'(OUTSTANDING));

  // Source selection. A request that has been presented but not yet accepted
  // keeps the bus (lock) so the memory never sees the request change under it.
  always_comb begin
    sel     = SRC_I;
    present = 1'b0;
    if (issue_ok) begin
      if (lock_valid && ((lock_src == SRC_I) ? i_req : d_req)) begin
        sel     = lock_src;
        present = 1'b1;
      end else if (i_req && d_req) begin
        sel     = (last_grant == SRC_D) ? SRC_I : SRC_D;
        present = 1'b1;
      end else if (i_req) begin
        sel     = SRC_I;
        present = 1'b1;
      end else if (d_req) begin
        sel     = SRC_D;
        present = 1'b1;
      end
    end
  end

  // Bus request fields follow the selected source; idle bus is all zero.
  always_comb begin
    bus_addr    = '0;
    bus_data_wr = '0;
    bus_rd      = 1'b0;
    bus_wr      = '0;
    if (present) begin
      if (sel == SRC_I) begin
        bus_addr = mem_i_pc;
        bus_rd   = 1'b1;
      end else begin
        bus_addr    = mem_d_addr;
        bus_data_wr = mem_d_data_wr;
        bus_wr      = mem_d_wr;
        bus_rd      = ~d_is_wr;
      end
    end
  end

  assign accepted     = present & bus_accept;
  assign mem_i_accept = accepted & (sel == SRC_I);
  assign mem_d_accept = accepted & (sel == SRC_D);

  assign push_entry.src = sel;
  assign push_entry.tag = (sel == SRC_D) ? mem_d_req_tag : '0;

  assign resp_pop = rst & bus_ack & ~fifo_empty;

  core_mem_arb_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (accepted & ~fifo_full),
    .push_entry (push_entry),
    .pop        (resp_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // Zero-latency response steering; data/error/tag are forced to 0 when idle.
  always_comb begin
    mem_i_valid    = 1'b0;
    mem_i_error    = 1'b0;
    mem_i_inst     = '0;
    mem_d_ack      = 1'b0;
    mem_d_error    = 1'b0;
    mem_d_data_rd  = '0;
    mem_d_resp_tag = '0;
    if (resp_pop) begin
      if (fifo_head.src == SRC_I) begin
        mem_i_valid = 1'b1;
        mem_i_error = bus_error;
        mem_i_inst  = bus_data_rd;
      end else begin
        mem_d_ack      = 1'b1;
        mem_d_error    = bus_error;
        mem_d_data_rd  = bus_data_rd;
        mem_d_resp_tag = fifo_head.tag;
      end
    end
  end

  // last_grant resets to D so the fetch port wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_valid   <= 1'b0;
      lock_src     <= SRC_I;
      last_grant   <= SRC_D;
      protocol_err <= 1'b0;
    end else begin
      lock_valid <= present & ~bus_accept;
      if (present)  lock_src   <= sel;
      if (accepted) last_grant <= sel;
      if (bus_ack && fifo_empty) protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb/tb_core_mem_arbiter.sv - self-checking bench for core_mem_arbiter

module tb_core_mem_arbiter;
  import core_mem_arb_pkg::*;

  localparam int OUTST = 2;

  logic        clk;
  logic        rst;
  logic        mem_i_rd;
  logic [31:0] mem_i_pc;
  logic        mem_i_accept;
  logic        mem_i_valid;
  logic        mem_i_error;
  logic [31:0] mem_i_inst;
  logic [31:0] mem_d_addr;
  logic [31:0] mem_d_data_wr;
  logic        mem_d_rd;
  logic [3:0]  mem_d_wr;
  logic [10:0] mem_d_req_tag;
  logic        mem_d_accept;
  logic        mem_d_ack;
  logic        mem_d_error;
  logic [31:0] mem_d_data_rd;
  logic [10:0] mem_d_resp_tag;
  logic [31:0] bus_addr;
  logic [31:0] bus_data_wr;
  logic        bus_rd;
  logic [3:0]  bus_wr;
  logic        bus_accept;
  logic        bus_ack;
  logic        bus_error;
  logic [31:0] bus_data_rd;
  logic        protocol_err;

  core_mem_arbiter #(.OUTSTANDING(OUTST)) dut (
    .clk(clk), .rst(rst),
    .mem_i_rd(mem_i_rd), .mem_i_pc(mem_i_pc), .mem_i_accept(mem_i_accept),
    .mem_i_valid(mem_i_valid), .mem_i_error(mem_i_error), .mem_i_inst(mem_i_inst),
    .mem_d_addr(mem_d_addr), .mem_d_data_wr(mem_d_data_wr), .mem_d_rd(mem_d_rd),
    .mem_d_wr(mem_d_wr), .mem_d_req_tag(mem_d_req_tag), .mem_d_accept(mem_d_accept),
    .mem_d_ack(mem_d_ack), .mem_d_error(mem_d_error), .mem_d_data_rd(mem_d_data_rd),
    .mem_d_resp_tag(mem_d_resp_tag),
    .bus_addr(bus_addr), .bus_data_wr(bus_data_wr), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_accept(bus_accept), .bus_ack(bus_ack), .bus_error(bus_error),
    .bus_data_rd(bus_data_rd), .protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    mem_i_rd      = 1'b0;
    mem_i_pc      = '0;
    mem_d_addr    = '0;
    mem_d_data_wr = '0;
    mem_d_rd      = 1'b0;
    mem_d_wr      = '0;
    mem_d_req_tag = '0;
    bus_accept    = 1'b0;
    bus_ack       = 1'b0;
    bus_error     = 1'b0;
    bus_data_rd   = '0;
  endtask

  task automatic next();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0x0 expected 0x1");
    $fatal(1, "timeout");
  end

  // Reference model state
  arb_entry_t  q[$];
  logic        m_lock_v;
  src_e        m_lock_src;
  src_e        m_last;
  logic        m_perr;
  logic        ip, dp, d_rd_v;
  logic [3:0]  d_wr_v;
  logic        e_pres, e_acc, pop;
  src_e        e_src;
  arb_entry_t  h;

  initial begin
    // Reset with busy-looking inputs: everything must read zero.
    idle();
    rst = 1'b0;
    mem_i_rd = 1'b1; mem_i_pc = 32'h1234; mem_d_wr = 4'hF; bus_accept = 1'b1;
    bus_ack = 1'b1; bus_error = 1'b1; bus_data_rd = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    check("rst_bus_rd", 64'(bus_rd), 64'(0));
    check("rst_bus_wr", 64'(bus_wr), 64'(0));
    check("rst_bus_addr", 64'(bus_addr), 64'(0));
    check("rst_accepts", 64'({mem_i_accept, mem_d_accept}), 64'(0));
    check("rst_resp", 64'({mem_i_valid, mem_d_ack, mem_i_error, mem_d_error}), 64'(0));
    check("rst_resp_data", 64'({mem_i_inst, mem_d_data_rd}), 64'(0));
    check("rst_perr", 64'(protocol_err), 64'(0));

    // Tie from reset: I first, then D.
    @(negedge clk);
    rst = 1'b1;
    idle();
    mem_i_rd = 1'b1; mem_i_pc = 32'h100;
    mem_d_rd = 1'b1; mem_d_addr = 32'h2000; mem_d_req_tag = 11'h05;
    bus_accept = 1'b1;
    #1;
    check("c1_i_acc", 64'(mem_i_accept), 64'(1));
    check("c1_d_acc", 64'(mem_d_accept), 64'(0));
    check("c1_addr", 64'(bus_addr), 64'(32'h100));
    check("c1_rd", 64'(bus_rd), 64'(1));
    next();
    #1;
    check("c2_d_acc", 64'(mem_d_accept), 64'(1));
    check("c2_i_acc", 64'(mem_i_accept), 64'(0));
    check("c2_addr", 64'(bus_addr), 64'(32'h2000));
    next();
    // Two outstanding: bus stalls.
    mem_d_rd = 1'b0;
    #1;
    check("full_bus_rd", 64'(bus_rd), 64'(0));
    check("full_accepts", 64'({mem_i_accept, mem_d_accept}), 64'(0));
    next();
    bus_ack = 1'b1; bus_data_rd = 32'hAAAA0001;
    #1;
    check("ack1_i_valid", 64'(mem_i_valid), 64'(1));
    check("ack1_i_inst", 64'(mem_i_inst), 64'(32'hAAAA0001));
    check("ack1_d_ack", 64'(mem_d_ack), 64'(0));
    check("ack1_full_rd", 64'(bus_rd), 64'(0));
    check("ack1_i_acc", 64'(mem_i_accept), 64'(0));
    next();
    bus_data_rd = 32'hBBBB0002;
    #1;
    check("ack2_d_ack", 64'(mem_d_ack), 64'(1));
    check("ack2_d_data", 64'(mem_d_data_rd), 64'(32'hBBBB0002));
    check("ack2_d_tag", 64'(mem_d_resp_tag), 64'(11'h05));
    check("ack2_i_quiet", 64'({mem_i_valid, mem_i_inst}), 64'(0));
    check("ack2_i_acc", 64'(mem_i_accept), 64'(1));
    next();
    mem_i_rd = 1'b0; bus_data_rd = 32'h33; bus_error = 1'b1;
    #1;
    check("ack3_i_resp", 64'({mem_i_valid, mem_i_error, mem_i_inst}), {31'd0, 1'b1, 1'b1, 32'h33});
    check("ack3_d_quiet", 64'({mem_d_ack, mem_d_error, mem_d_data_rd}), 64'(0));
    next();
    // D read so that the next tie would favour I.
    bus_ack = 1'b0; bus_error = 1'b0;
    mem_d_rd = 1'b1; mem_d_addr = 32'h44; mem_d_req_tag = 11'h1;
    #1;
    check("pre_d_acc", 64'(mem_d_accept), 64'(1));
    next();
    mem_d_rd = 1'b0; bus_accept = 1'b0; bus_ack = 1'b1; bus_data_rd = 32'h55;
    #1;
    check("pre_d_resp", 64'({mem_d_ack, mem_d_resp_tag, mem_d_data_rd}), {20'd0, 1'b1, 11'h1, 32'h55});
    next();
    // Locked D write while I also requests.
    bus_ack = 1'b0; bus_data_rd = '0;
    mem_d_rd = 1'b1; mem_d_wr = 4'b0011; mem_d_addr = 32'h3000;
    mem_d_data_wr = 32'hDEADBEEF; mem_d_req_tag = 11'h7;
    #1;
    check("wr_bus_wr", 64'(bus_wr), 64'(4'b0011));
    check("wr_bus_rd", 64'(bus_rd), 64'(0));
    check("wr_wdata", 64'(bus_data_wr), 64'(32'hDEADBEEF));
    next();
    mem_i_rd = 1'b1; mem_i_pc = 32'h200;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("lock%0d_wr", k), 64'({bus_wr, bus_addr}), {28'd0, 4'b0011, 32'h3000});
      check($sformatf("lock%0d_acc", k), 64'({mem_i_accept, mem_d_accept}), 64'(0));
      next();
    end
    bus_accept = 1'b1;
    #1;
    check("lock_rel_acc", 64'({mem_i_accept, mem_d_accept}), 64'(2'b01));
    check("lock_rel_wr", 64'(bus_wr), 64'(4'b0011));
    next();
    mem_d_rd = 1'b0; mem_d_wr = '0;
    #1;
    check("after_lock_i_acc", 64'(mem_i_accept), 64'(1));
    check("after_lock_addr", 64'({bus_wr, bus_addr}), 64'(32'h200));
    next();
    mem_i_rd = 1'b0; bus_accept = 1'b0; bus_ack = 1'b1; bus_data_rd = 32'h66;
    #1;
    check("wr_ack", 64'({mem_d_ack, mem_d_resp_tag}), 64'({1'b1, 11'h7}));
    next();
    bus_data_rd = 32'h77;
    #1;
    check("i_ack_after_wr", 64'({mem_i_valid, mem_i_inst}), {31'd0, 1'b1, 32'h77});
    next();
    // Stray ack.
    bus_data_rd = 32'h99;
    #1;
    check("stray_no_strobe", 64'({mem_i_valid, mem_d_ack}), 64'(0));
    check("stray_perr_before", 64'(protocol_err), 64'(0));
    next();
    bus_ack = 1'b0;
    #1;
    check("stray_perr_set", 64'(protocol_err), 64'(1));
    repeat (3) next();
    #1;
    check("stray_perr_sticky", 64'(protocol_err), 64'(1));
    // Reset with two outstanding.
    mem_i_rd = 1'b1; mem_i_pc = 32'h300; bus_accept = 1'b1;
    next();
    mem_i_rd = 1'b0; mem_d_rd = 1'b1; mem_d_addr = 32'h400; mem_d_req_tag = 11'h9;
    next();
    mem_i_rd = 1'b1;
    rst = 1'b0;
    bus_ack = 1'b1;
    #1;
    check("mid_rst_bus_rd", 64'(bus_rd), 64'(0));
    check("mid_rst_acc", 64'({mem_i_accept, mem_d_accept}), 64'(0));
    check("mid_rst_resp", 64'({mem_i_valid, mem_d_ack}), 64'(0));
    check("mid_rst_perr", 64'(protocol_err), 64'(0));
    check("mid_rst_count", 64'(dut.fifo_count), 64'(0));
    next();
    rst = 1'b1; bus_ack = 1'b0; mem_d_rd = 1'b0; mem_i_pc = 32'h500;
    #1;
    check("post_rst_i_acc", 64'(mem_i_accept), 64'(1));
    check("post_rst_addr", 64'(bus_addr), 64'(32'h500));
    next();
    mem_i_rd = 1'b0; bus_accept = 1'b0; bus_ack = 1'b1; bus_data_rd = 32'h88;
    #1;
    check("post_rst_i_resp", 64'({mem_i_valid, mem_i_inst}), {31'd0, 1'b1, 32'h88});
    next();
    #1;
    check("post_rst_extra_ack", 64'({mem_i_valid, mem_d_ack}), 64'(0));
    next();
    bus_ack = 1'b0;
    #1;
    check("post_rst_perr", 64'(protocol_err), 64'(1));

    // Randomized traffic against the reference model.
    rst = 1'b0;
    idle();
    next();
    rst = 1'b1;
    q.delete();
    m_lock_v = 1'b0; m_lock_src = SRC_I; m_last = SRC_D; m_perr = 1'b0;
    ip = 1'b0; dp = 1'b0; d_rd_v = 1'b0; d_wr_v = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!ip && $urandom_range(0, 99) < 40) begin
        ip = 1'b1;
        mem_i_pc = $urandom;
      end
      if (!dp && $urandom_range(0, 99) < 40) begin
        dp = 1'b1;
        mem_d_addr = $urandom;
        mem_d_data_wr = $urandom;
        mem_d_req_tag = 11'($urandom);
        case ($urandom_range(0, 2))
          0:       begin d_rd_v = 1'b1; d_wr_v = '0; end
          1:       begin d_rd_v = 1'b0; d_wr_v = 4'($urandom_range(1, 15)); end
          default: begin d_rd_v = 1'b1; d_wr_v = 4'($urandom_range(1, 15)); end
        endcase
      end
      mem_i_rd = ip;
      mem_d_rd = dp & d_rd_v;
      mem_d_wr = dp ? d_wr_v : 4'h0;
      bus_accept = ($urandom_range(0, 99) < 60);
      bus_ack = (q.size() > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 1);
      bus_data_rd = $urandom;
      bus_error = ($urandom_range(0, 99) < 20);

      // Who owns the bus this cycle.
      e_pres = 1'b0;
      e_src = SRC_I;
      if (q.size() < OUTST) begin
        if (m_lock_v && ((m_lock_src == SRC_I) ? ip : dp)) begin
          e_pres = 1'b1; e_src = m_lock_src;
        end else if (ip && dp) begin
          e_pres = 1'b1; e_src = (m_last == SRC_I) ? SRC_D : SRC_I;
        end else if (ip || dp) begin
          e_pres = 1'b1; e_src = ip ? SRC_I : SRC_D;
        end
      end
      e_acc = e_pres && bus_accept;
      pop = bus_ack && (q.size() > 0);
      h = pop ? q[0] : '0;

      #1;
      check("r_acc", 64'({mem_i_accept, mem_d_accept}),
            64'({e_acc && e_src == SRC_I, e_acc && e_src == SRC_D}));
      check("r_bus_rd", 64'(bus_rd), 64'(e_pres && (e_src == SRC_I || d_wr_v == 4'h0)));
      check("r_bus_wr", 64'(bus_wr), 64'((e_pres && e_src == SRC_D) ? d_wr_v : 4'h0));
      check("r_bus_addr", 64'(bus_addr), 64'(!e_pres ? 32'h0 : (e_src == SRC_I ? mem_i_pc : mem_d_addr)));
      check("r_bus_wdata", 64'(bus_data_wr), 64'((e_pres && e_src == SRC_D) ? mem_d_data_wr : 32'h0));
      if (pop && h.src == SRC_I)
        check("r_i_resp", 64'({mem_i_valid, mem_i_error, mem_i_inst}), 64'({1'b1, bus_error, bus_data_rd}));
      else
        check("r_i_resp", 64'({mem_i_valid, mem_i_error, mem_i_inst}), 64'(0));
      if (pop && h.src == SRC_D)
        check("r_d_resp", 64'({mem_d_ack, mem_d_error, mem_d_resp_tag, mem_d_data_rd}),
              64'({1'b1, bus_error, h.tag, bus_data_rd}));
      else
        check("r_d_resp", 64'({mem_d_ack, mem_d_error, mem_d_resp_tag, mem_d_data_rd}), 64'(0));
      check("r_perr", 64'(protocol_err), 64'(m_perr));

      // Advance the model to the state after this clock edge.
      if (pop) void'(q.pop_front());
      else if (bus_ack) m_perr = 1'b1;
      if (e_acc) begin
        q.push_back('{src: e_src, tag: (e_src == SRC_D) ? mem_d_req_tag : 11'h0});
        m_last = e_src;
        if (e_src == SRC_I) ip = 1'b0;
        else dp = 1'b0;
      end
      m_lock_v = e_pres && !bus_accept;
      m_lock_src = e_src;
      next();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
